instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  instruction request present.
REQ-004 in_ready  out  1  encoder can accept a request; high when FIFO not full.
REQ-005 in_class  in  7  one-hot class; bit6..0 = R, ori, lw, sw, beq, lui, jal.
REQ-006 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-007 in_funct  in  6  R-type function code.
REQ-008 in_imm  in  16  immediate / branch offset.
REQ-009 in_target  in  26  jal word target.
REQ-010 im_we  out  1  instruction-memory write strobe.
REQ-011 im_ready  in  1  memory accepts the write this cycle.
REQ-012 im_addr  out  10  word address of current write.
REQ-013 im_wdata  out  32  encoded instruction.
REQ-014 bad_cnt  out  8  count of rejected requests, saturating.
REQ-015 wrapped  out  1  sticky; address counter has wrapped.

Function
REQ-016 Request accepted in a cycle where in_valid and in_ready are both 1.
REQ-017 Accepted request with exactly one in_class bit set SHALL be encoded and pushed into a 4-entry FIFO in that cycle.
REQ-018 Encoding: R = {000000, rs, rt, rd, 00000, funct}; ori 001101, lw 100011, sw 101011, beq 000100 = {op, rs, rt, imm}; lui = {001111, 00000, rt, imm}; jal = {000011, target}.
REQ-019 Accepted request with zero or multiple class bits SHALL be discarded (no push) and increment bad_cnt, saturating at 255.
REQ-020 in_ready SHALL equal (FIFO count != 4); a pop in the same cycle does not raise in_ready for that cycle.
REQ-021 im_we SHALL equal (FIFO count != 0); im_wdata is the FIFO head; im_addr is the address counter.
REQ-022 Write completes in a cycle where im_we and im_ready are both 1: FIFO pops, im_addr increments by 1.
REQ-023 im_addr SHALL wrap 1023 -> 0 on completion; the wrap sets wrapped, which stays 1 until reset.
REQ-024 im_we, im_wdata, im_addr SHALL hold stable while im_we=1 and im_ready=0.
REQ-025 Minimum latency: a request accepted at cycle N first appears on im_we at cycle N+1.
REQ-026 Simultaneous push and pop SHALL leave FIFO count unchanged and preserve order.
REQ-027 Throughput: one instruction per cycle sustained when im_ready is held 1.

Reset
REQ-028 On reset assertion, asynchronously: FIFO empty, im_addr=0, bad_cnt=0, wrapped=0, im_we=0, in_ready=1, im_wdata=0.
REQ-029 Reset mid-operation SHALL drop all queued instructions; no write strobe during or in the first cycle after reset.

Structure
REQ-030 Opcode constants (000000, 001101, 100011, 101011, 000100, 001111, 000011), class bit positions and field bit ranges SHALL live in a shared package also used by the CPU decoder.
REQ-031 FIFO SHALL be a sub-module, instr_fifo (4 x 32, count output, async active-high reset).
REQ-032 Encoding logic is combinational in instr_encoder; address counter, bad_cnt, wrapped are registers in instr_encoder.

Verification
REQ-033 ori class, rs=1, rt=2, imm=0x1234, im_ready=1 -> next cycle im_we=1, im_addr=0, im_wdata=0x34221234.
REQ-034 jal target=0x0000C00 then R rs=8, rt=9, rd=10, funct=0x21 back-to-back -> writes 0x0C000C00 at addr 0, 0x0109502 1 at addr 1 (0x01095021).
REQ-035 im_ready=0, push 6 valid requests -> in_ready low after 4 accepted, outputs held; release im_ready -> 4 writes in order, addr 0..3.
REQ-036 in_class=0000000 then 0000011 -> no writes, bad_cnt=2; 256 more bad requests -> bad_cnt=255.
REQ-037 1025 lui writes with im_ready=1 -> write 1024 at addr 1023, write 1025 at addr 0, wrapped=1.
REQ-038 Reset asserted with 3 queued entries and im_addr=5 -> immediately im_we=0, im_addr=0, in_ready=1; no queued entry written after release.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions: opcodes, class bit positions and field ranges.
// Used by the encoder here and by the CPU decoder.
package instr_encoder_pkg;

    localparam int CLASS_W = 7;

    // Bit positions of each class inside the one-hot class vector
    localparam int CLS_R   = 6;
    localparam int CLS_ORI = 5;
    localparam int CLS_LW  = 4;
    localparam int CLS_SW  = 3;
    localparam int CLS_BEQ = 2;
    localparam int CLS_LUI = 1;
    localparam int CLS_JAL = 0;

    localparam logic [CLASS_W-1:0] CLASS_R   = 7'b1000000;
    localparam logic [CLASS_W-1:0] CLASS_ORI = 7'b0100000;
    localparam logic [CLASS_W-1:0] CLASS_LW  = 7'b0010000;
    localparam logic [CLASS_W-1:0] CLASS_SW  = 7'b0001000;
    localparam logic [CLASS_W-1:0] CLASS_BEQ = 7'b0000100;
    localparam logic [CLASS_W-1:0] CLASS_LUI = 7'b0000010;
    localparam logic [CLASS_W-1:0] CLASS_JAL = 7'b0000001;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    function automatic logic is_onehot(input logic [CLASS_W-1:0] c);
        return (c != '0) && ((c & (c - 7'd1)) == '0);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding encoded instructions awaiting a memory write.
// DEPTH must be a power of two so the pointers wrap naturally.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests into 32-bit words and streams them into
// instruction memory at consecutive word addresses through a 4-entry FIFO.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CLASS_W-1:0]  in_class,
    input  logic [4:0]          in_rs,
    input  logic [4:0]          in_rt,
    input  logic [4:0]          in_rd,
    input  logic [5:0]          in_funct,
    input  logic [15:0]         in_imm,
    input  logic [25:0]         in_target,
    output logic                im_we,
    input  logic                im_ready,
    output logic [9:0]          im_addr,
    output logic [31:0]         im_wdata,
    output logic [7:0]          bad_cnt,
    output logic                wrapped
);

    instr_fields_t f;
    logic [31:0]   enc_word;
    logic [2:0]    fifo_count;
    logic          accept;
    logic          push;
    logic          bad;
    logic          pop;

    assign f = '{rs: in_rs, rt: in_rt, rd: in_rd, funct: in_funct,
                 imm: in_imm, target: in_target};

    assign in_ready = (fifo_count != 3'd4);
    assign im_we    = (fifo_count != 3'd0);
    assign accept   = in_valid && in_ready;
    assign push     = accept && is_onehot(in_class);
    assign bad      = accept && !is_onehot(in_class);
    assign pop      = im_we && im_ready;

    always_comb begin
        enc_word = '0;
        case (in_class)
            CLASS_R: begin
                enc_word[OP_MSB:OP_LSB]       = OP_RTYPE;
                enc_word[RS_MSB:RS_LSB]       = f.rs;
                enc_word[RT_MSB:RT_LSB]       = f.rt;
                enc_word[RD_MSB:RD_LSB]       = f.rd;
                enc_word[SHAMT_MSB:SHAMT_LSB] = 5'd0;
                enc_word[FUNCT_MSB:FUNCT_LSB] = f.funct;
            end
            CLASS_ORI, CLASS_LW, CLASS_SW, CLASS_BEQ: begin
                enc_word[OP_MSB:OP_LSB]   = in_class[CLS_ORI] ? OP_ORI :
                                            in_class[CLS_LW]  ? OP_LW  :
                                            in_class[CLS_SW]  ? OP_SW  : OP_BEQ;
                enc_word[RS_MSB:RS_LSB]   = f.rs;
                enc_word[RT_MSB:RT_LSB]   = f.rt;
                enc_word[IMM_MSB:IMM_LSB] = f.imm;
            end
            CLASS_LUI: begin
                enc_word[OP_MSB:OP_LSB]   = OP_LUI;
                enc_word[RS_MSB:RS_LSB]   = 5'd0;
                enc_word[RT_MSB:RT_LSB]   = f.rt;
                enc_word[IMM_MSB:IMM_LSB] = f.imm;
            end
            CLASS_JAL: begin
                enc_word[OP_MSB:OP_LSB]         = OP_JAL;
                enc_word[TARGET_MSB:TARGET_LSB] = f.target;
            end
            default: enc_word = '0;
        endcase
    end

    instr_fifo #(.DEPTH(4), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (enc_word),
        .pop   (pop),
        .dout  (im_wdata),
        .count (fifo_count)
    );

    // The address counter wraps modulo 1024; the first wrap is remembered until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_addr <= '0;
            bad_cnt <= '0;
            wrapped <= 1'b0;
        end else begin
            if (pop) begin
                im_addr <= im_addr + 10'd1;
                if (im_addr == 10'd1023) wrapped <= 1'b1;
            end
            if (bad && (bad_cnt != 8'hFF)) bad_cnt <= bad_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, checked against a queue-based
// reference model of the encode/FIFO/address behaviour.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_class;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        im_we;
    logic        im_ready;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [7:0]  bad_cnt;
    logic        wrapped;

    int          vec_count = 0;
    int          err_count = 0;

    logic [31:0] m_q[$];
    int          m_addr;
    int          m_bad;
    bit          m_wrapped;

    instr_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .im_we     (im_we),
        .im_ready  (im_ready),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .bad_cnt   (bad_cnt),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_encode(input logic [6:0] c, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [4:0] rd,
                                                input logic [5:0] fn, input logic [15:0] imm,
                                                input logic [25:0] tgt);
        case (c)
            7'b1000000: return {6'b000000, rs, rt, rd, 5'b00000, fn};
            7'b0100000: return {6'b001101, rs, rt, imm};
            7'b0010000: return {6'b100011, rs, rt, imm};
            7'b0001000: return {6'b101011, rs, rt, imm};
            7'b0000100: return {6'b000100, rs, rt, imm};
            7'b0000010: return {6'b001111, 5'b00000, rt, imm};
            default:    return {6'b000011, tgt};
        endcase
    endfunction

    // Checks current outputs against the model, drives one cycle, then advances the model
    task automatic applyStimulus(input logic v, input logic [6:0] c, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn,
                                 input logic [15:0] imm, input logic [25:0] tgt, input logic rdy);
        bit acc;
        bit pop;
        in_valid = v; in_class = c; in_rs = rs; in_rt = rt; in_rd = rd;
        in_funct = fn; in_imm = imm; in_target = tgt; im_ready = rdy;
        checkOutput("in_ready", 32'(in_ready), 32'(m_q.size() != 4));
        checkOutput("im_we", 32'(im_we), 32'(m_q.size() != 0));
        checkOutput("im_addr", 32'(im_addr), 32'(m_addr));
        checkOutput("bad_cnt", 32'(bad_cnt), 32'(m_bad));
        checkOutput("wrapped", 32'(wrapped), 32'(m_wrapped));
        if (m_q.size() != 0) checkOutput("im_wdata", im_wdata, m_q[0]);
        acc = v && (m_q.size() != 4);
        pop = (m_q.size() != 0) && rdy;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(m_q.pop_front());
            if (m_addr == 1023) begin
                m_addr = 0;
                m_wrapped = 1'b1;
            end else begin
                m_addr++;
            end
        end
        if (acc) begin
            if ($countones(c) == 1) m_q.push_back(ref_encode(c, rs, rt, rd, fn, imm, tgt));
            else if (m_bad < 255) m_bad++;
        end
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, rdy);
    endtask

    task automatic randGood(input logic [6:0] c, input logic rdy);
        applyStimulus(1'b1, c, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                      16'($urandom), 26'($urandom), rdy);
    endtask

    task automatic doReset();
        reset = 1'b1;
        #1;
        checkOutput("rst_im_we", 32'(im_we), 32'd0);
        checkOutput("rst_im_addr", 32'(im_addr), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_im_wdata", im_wdata, 32'd0);
        checkOutput("rst_bad_cnt", 32'(bad_cnt), 32'd0);
        checkOutput("rst_wrapped", 32'(wrapped), 32'd0);
        m_q.delete();
        m_addr = 0;
        m_bad = 0;
        m_wrapped = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [6:0] rand_class();
        logic [6:0] c;
        if ($urandom_range(0, 9) < 8) begin
            c = 7'd1;
            c = c << $urandom_range(0, 6);
        end else begin
            c = 7'($urandom);
        end
        return c;
    endfunction

    initial begin
        logic [6:0] c;
        reset = 1'b0;
        in_valid = 1'b0; in_class = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_funct = '0; in_imm = '0; in_target = '0; im_ready = 1'b0;
        #2;
        doReset();

        // ori r2 <- r1 | 0x1234
        applyStimulus(1'b1, 7'b0100000, 5'd1, 5'd2, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1);
        checkOutput("ori_we", 32'(im_we), 32'd1);
        checkOutput("ori_addr", 32'(im_addr), 32'd0);
        checkOutput("ori_word", im_wdata, 32'h34221234);
        idle(1'b1);

        // jal then R-type back to back
        doReset();
        applyStimulus(1'b1, 7'b0000001, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000C00, 1'b1);
        checkOutput("jal_word", im_wdata, 32'h0C000C00);
        checkOutput("jal_addr", 32'(im_addr), 32'd0);
        applyStimulus(1'b1, 7'b1000000, 5'd8, 5'd9, 5'd10, 6'h21, 16'd0, 26'd0, 1'b1);
        checkOutput("r_word", im_wdata, 32'h01095021);
        checkOutput("r_addr", 32'(im_addr), 32'd1);
        idle(1'b1);

        // Back-pressure: memory stalls while six requests arrive
        doReset();
        for (int i = 0; i < 6; i++) randGood(rand_class() | 7'd0 ? 7'b0010000 : 7'b0010000, 1'b0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp_addr", 32'(im_addr), 32'd0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        checkOutput("bp_drained_addr", 32'(im_addr), 32'd4);

        // Malformed classes and saturation
        doReset();
        applyStimulus(1'b1, 7'b0000000, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b1);
        applyStimulus(1'b1, 7'b0000011, 5'd1, 5'd1, 5'd1, 6'd1, 16'd1, 26'd1, 1'b1);
        checkOutput("bad_two", 32'(bad_cnt), 32'd2);
        checkOutput("bad_no_we", 32'(im_we), 32'd0);
        for (int i = 0; i < 256; i++) begin
            c = 7'($urandom);
            if ($countones(c) == 1) c = 7'b1100000;
            applyStimulus(1'b1, c, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                          16'($urandom), 26'($urandom), 1'($urandom));
        end
        checkOutput("bad_sat", 32'(bad_cnt), 32'd255);

        // Address wrap after 1024 writes
        doReset();
        for (int i = 0; i < 1025; i++) begin
            randGood(7'b0000010, 1'b1);
            if (i == 1023) begin
                checkOutput("wrap_addr1023", 32'(im_addr), 32'd1023);
                checkOutput("wrap_not_yet", 32'(wrapped), 32'd0);
            end
        end
        checkOutput("wrap_addr0", 32'(im_addr), 32'd0);
        checkOutput("wrap_sticky", 32'(wrapped), 32'd1);
        idle(1'b1);
        checkOutput("wrap_after", 32'(im_addr), 32'd1);

        // Reset mid-operation with queued entries
        doReset();
        for (int i = 0; i < 5; i++) randGood(7'b0100000, 1'b1);
        idle(1'b1);
        for (int i = 0; i < 3; i++) randGood(7'b1000000, 1'b0);
        checkOutput("pre_rst_addr", 32'(im_addr), 32'd5);
        checkOutput("pre_rst_we", 32'(im_we), 32'd1);
        doReset();
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) randGood(rand_class(), 1'($urandom_range(0, 3) != 0));
            else idle(1'($urandom));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
